// File: rtl/leaf_rx_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : leaf_rx_port_if
//  Description : Bundle of the BFT-side, user-side and credit-side signals of
//                a leaf receive port.
//                slave  modport : seen by leaf_rx_port
//                master modport : seen by the BFT / user / credit consumer
//  Signals     : din_leaf_bft2interface   BFT packet into the port
//                dout_leaf_interface2user head-of-FIFO payload, vld_/ack_ pair
//                src_leaf / src_port      destination of credit packets
//                dout_credit, credit_vld / credit_ack  credit handshake
//                overflow, seq_err        sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
interface leaf_rx_port_if #(
    parameter int PACKET_BITS  = 49,
    parameter int PAYLOAD_BITS = 32
);
    logic [PACKET_BITS-1:0]  din_leaf_bft2interface;
    logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user;
    logic                    vld_interface2user;
    logic                    ack_user2interface;
    logic [4:0]              src_leaf;
    logic [3:0]              src_port;
    logic [PACKET_BITS-1:0]  dout_credit;
    logic                    credit_vld;
    logic                    credit_ack;
    logic                    overflow;
    logic                    seq_err;

    modport slave (
        input  din_leaf_bft2interface,
        input  ack_user2interface,
        input  src_leaf,
        input  src_port,
        input  credit_ack,
        output dout_leaf_interface2user,
        output vld_interface2user,
        output dout_credit,
        output credit_vld,
        output overflow,
        output seq_err
    );

    modport master (
        output din_leaf_bft2interface,
        output ack_user2interface,
        output src_leaf,
        output src_port,
        output credit_ack,
        input  dout_leaf_interface2user,
        input  vld_interface2user,
        input  dout_credit,
        input  credit_vld,
        input  overflow,
        input  seq_err
    );
endinterface
`default_nettype wire

// File: rtl/leaf_rx_port.sv
`default_nettype none
// ============================================================================
//  Module      : leaf_rx_port
//  Description : Receive side of a BFT leaf interface. Packets addressed to
//                PORT_ID are stored in a first-word-fall-through FIFO for the
//                user; every FREESPACE_UPDATE_SIZE consumed words a credit
//                packet is returned to the sender (src_leaf/src_port).
//  Ports       : clk    - sole clock, rising edge
//                reset  - synchronous, active-high
//                bus    - leaf_rx_port_if.slave (packet in, user payload
//                         out, credit packet out, error flags)
//  Option      : LEAF_RX_SEQ_CHECK_EN - when defined, packets whose sequence
//                field differs from the expected value are dropped and flag
//                seq_err; otherwise the sequence field is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module leaf_rx_port #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int PORT_ID               = 2,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  wire logic       clk,
    input  wire logic       reset,
    leaf_rx_port_if.slave   bus
);

    localparam int c_DEPTH    = 1 << NUM_ADDR_BITS;
    localparam int c_VLD_BIT  = PACKET_BITS - 1;
    localparam int c_PORT_MSB = PACKET_BITS - 7;
    localparam int c_SEQ_LSB  = PAYLOAD_BITS;

    localparam logic [3:0]               c_PORT = 4'(PORT_ID);
    localparam logic [NUM_ADDR_BITS:0]   c_FULL = {1'b1, {NUM_ADDR_BITS{1'b0}}};
    localparam logic [NUM_ADDR_BITS:0]   c_FS   = (NUM_ADDR_BITS+1)'(FREESPACE_UPDATE_SIZE);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [PAYLOAD_BITS-1:0]  r_mem [c_DEPTH];
    logic [NUM_ADDR_BITS-1:0] r_wr_ptr;
    logic [NUM_ADDR_BITS-1:0] r_rd_ptr;
    logic [NUM_ADDR_BITS:0]   r_count;
    logic [NUM_ADDR_BITS:0]   r_consumed;
    logic                     r_overflow;
    logic                     r_seq_err;
    logic [PACKET_BITS-1:0]   r_credit_pkt;
    state_t                   r_state;
    state_t                   w_state_nxt;

    logic w_accept;
    logic w_seq_ok;
    logic w_seq_bad;
    logic w_full;
    logic w_vld;
    logic w_pop;
    logic w_push;
    logic w_ovf_set;
    logic w_credit_vld;
    logic w_enter_send;
    logic w_credit_done;

    logic [PAYLOAD_BITS-1:0] w_payload;
    logic [3:0]              w_port;

    assign w_payload = bus.din_leaf_bft2interface[PAYLOAD_BITS-1:0];
    assign w_port    = bus.din_leaf_bft2interface[c_PORT_MSB -: 4];
    assign w_accept  = bus.din_leaf_bft2interface[c_VLD_BIT] && (w_port == c_PORT);

`ifdef LEAF_RX_SEQ_CHECK_EN
    logic [NUM_ADDR_BITS-1:0] r_exp_seq;

    assign w_seq_ok  = (bus.din_leaf_bft2interface[c_SEQ_LSB +: NUM_ADDR_BITS] == r_exp_seq);
    assign w_seq_bad = w_accept && !w_seq_ok;

    // Expected sequence advances only for packets that actually land in the
    // FIFO, so a dropped (overflowed) packet can be resent with the same seq.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp_seq <= '0;
        end else if (w_push) begin
            r_exp_seq <= r_exp_seq + 1'b1;
        end
    end
`else
    logic [NUM_ADDR_BITS-1:0] w_unused_seq;

    assign w_seq_ok     = 1'b1;
    assign w_seq_bad    = 1'b0;
    assign w_unused_seq = bus.din_leaf_bft2interface[c_SEQ_LSB +: NUM_ADDR_BITS];
`endif

    // Leaf field of incoming packets is not needed by the receiver.
    logic [4:0] w_unused_leaf;
    assign w_unused_leaf = bus.din_leaf_bft2interface[PACKET_BITS-2 -: 5];

    // ------------------------------------------------------------------------
    // FIFO control. A full FIFO still accepts a packet when the head is being
    // popped in the same cycle, since that slot frees up at the same edge.
    // ------------------------------------------------------------------------
    assign w_full    = (r_count == c_FULL);
    assign w_vld     = (r_count != '0);
    assign w_pop     = w_vld && bus.ack_user2interface;
    assign w_push    = w_accept && w_seq_ok && (!w_full || w_pop);
    assign w_ovf_set = w_accept && w_seq_ok && w_full && !w_pop;

    // Memory array is left unreset so it maps onto RAM; the output mux below
    // hides stale contents while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= w_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
            if (w_seq_bad) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Credit return. Pops keep counting while a credit is outstanding; on the
    // handshake one credit's worth is subtracted from the running total.
    // ------------------------------------------------------------------------
    assign w_credit_done = (r_state == SEND) && bus.credit_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_consumed <= '0;
        end else if (w_credit_done) begin
            r_consumed <= r_consumed - c_FS + {{NUM_ADDR_BITS{1'b0}}, w_pop};
        end else begin
            r_consumed <= r_consumed + {{NUM_ADDR_BITS{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_vld = 1'b0;
        w_enter_send = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_consumed >= c_FS) begin
                    w_state_nxt  = SEND;
                    w_enter_send = 1'b1;
                end
            end
            SEND: begin
                w_credit_vld = 1'b1;
                if (bus.credit_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Credit packet is captured once on entry to SEND so it stays stable even
    // if src_leaf/src_port move while waiting for credit_ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit_pkt <= '0;
        end else if (w_enter_send) begin
            r_credit_pkt <= {1'b1, bus.src_leaf, bus.src_port,
                             {NUM_ADDR_BITS{1'b0}},
                             PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE)};
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.vld_interface2user       = w_vld;
    assign bus.dout_leaf_interface2user = w_vld ? r_mem[r_rd_ptr] : '0;
    assign bus.credit_vld               = w_credit_vld;
    assign bus.dout_credit              = w_credit_vld ? r_credit_pkt : '0;
    assign bus.overflow                 = r_overflow;
`ifdef LEAF_RX_SEQ_CHECK_EN
    assign bus.seq_err                  = r_seq_err;
`else
    assign bus.seq_err                  = 1'b0;
    logic w_unused_seq_err;
    assign w_unused_seq_err = r_seq_err;
`endif

endmodule
`default_nettype wire

// File: doc/leaf_rx_port.md
LEAF_RX_PORT -- requirements
Module: leaf_rx_port

Interface
REQ-001 Parameter PACKET_BITS, 49, BFT packet width.
REQ-002 Parameter PAYLOAD_BITS, 32, payload width.
REQ-003 Parameter NUM_ADDR_BITS, 7, sequence field width; FIFO depth = 2^NUM_ADDR_BITS (128).
REQ-004 Parameter PORT_ID, 2, 4-bit input port number this block accepts.
REQ-005 Parameter FREESPACE_UPDATE_SIZE, 64, consumed words per credit packet.
REQ-006 clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 din_leaf_bft2interface  in  49  packet from BFT: [48] valid, [47:43] leaf, [42:39] port, [38:32] seq, [31:0] payload.
REQ-009 dout_leaf_interface2user  out  32  head-of-FIFO payload to user.
REQ-010 vld_interface2user  out  1  payload valid.
REQ-011 ack_user2interface  in  1  user accepts payload.
REQ-012 src_leaf / src_port  in  5 / 4  credit destination fields.
REQ-013 dout_credit  out  49  credit packet, same field layout as REQ-008.
REQ-014 credit_vld  out  1  credit packet valid.
REQ-015 credit_ack  in  1  credit packet taken.
REQ-016 overflow / seq_err  out  1 / 1  sticky error flags.

Function
REQ-017 Packet SHALL be accepted when din[48]=1 and din[42:39]=PORT_ID; all others ignored.
REQ-018 Accepted payload SHALL be written to a first-word-fall-through FIFO; vld_interface2user SHALL rise the cycle after the accepting edge (1-cycle latency).
REQ-019 vld_interface2user SHALL equal FIFO non-empty; dout SHALL hold the head word, stable while vld=1 and ack=0.
REQ-020 Pop SHALL occur only on a cycle with vld=1 and ack=1; ack with vld=0 SHALL be ignored.
REQ-021 Accepted packet while FIFO full and no same-cycle pop SHALL be dropped and set overflow; with same-cycle pop it SHALL be stored.
REQ-022 Pointers SHALL wrap modulo depth; occupancy counter SHALL be NUM_ADDR_BITS+1 bits.
REQ-023 Each pop SHALL increment a consumed counter (NUM_ADDR_BITS+1 bits).
REQ-024 Credit FSM states IDLE, SEND: IDLE->SEND when consumed >= FREESPACE_UPDATE_SIZE; SEND->IDLE on credit_vld&credit_ack.
REQ-025 On entering SEND, dout_credit SHALL latch {1, src_leaf, src_port, 7'd0, zero-extended FREESPACE_UPDATE_SIZE}; credit_vld=1 and dout_credit stable throughout SEND.
REQ-026 On the ack cycle consumed SHALL become consumed - FREESPACE_UPDATE_SIZE + (pop this cycle); pops during SEND keep accumulating.
REQ-027 credit_vld SHALL be 0 in IDLE and dout_credit SHALL be 0 when credit_vld=0.

Reset
REQ-028 Reset SHALL empty FIFO, clear consumed, expected seq and error flags, force IDLE; vld_interface2user=0, credit_vld=0, dout_credit=0, dout_leaf_interface2user=0.
REQ-029 Reset mid-SEND SHALL abandon the pending credit; packets arriving during reset SHALL be dropped without setting overflow.

Configuration
REQ-030 Macro LEAF_RX_SEQ_CHECK_EN defined: accepted packet with seq != expected (reset 0, +1 mod 128 per stored packet) SHALL be dropped and set seq_err; expected unchanged.
REQ-031 Macro undefined: seq field ignored, seq_err tied to 0.

Verification
REQ-032 Reset, then one packet port=2 payload 0xDEADBEEF seq 0 -> vld=1 next cycle, dout=0xDEADBEEF; ack -> vld=0.
REQ-033 Packet port=3 or valid bit 0 -> FIFO unchanged, vld stays 0.
REQ-034 129 packets, ack held 0 -> 128 stored, overflow=1; then drain 128 words in order.
REQ-035 64 pops, src_leaf=5'd4, src_port=4'd1, credit_ack held 0 for 3 cycles, 2 more pops -> dout_credit={1,4,1,0,64} stable, after ack consumed=2.
REQ-036 With LEAF_RX_SEQ_CHECK_EN: seq 0,1,3 -> third dropped, seq_err=1; without: all three stored, seq_err=0.
REQ-037 Full FIFO, simultaneous packet and pop -> packet stored, occupancy stays 128, overflow=0.
